// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pc_ctrl_pkg : state encoding, PC step and next-address select codes
// Revision    : 1.0
// ============================================================================
package pc_ctrl_pkg;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_SEQ    = 2'd1,
    SEL_TARGET = 2'd2
  } nsel_e;

endpackage : pc_ctrl_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// pc_next_sel : combinational next fetch address (hold / +PC_STEP / target)
// Revision    : 1.0
// ============================================================================
module pc_next_sel
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] cur_addr,
  input  logic [31:0] target,
  input  nsel_e       sel,
  output logic [31:0] next_addr
);

  always_comb begin
    next_addr = cur_addr;
    unique case (sel)
      SEL_SEQ:    next_addr = cur_addr + PC_STEP;  // natural 32-bit wrap
      SEL_TARGET: next_addr = target;
      default:    next_addr = cur_addr;
    endcase
  end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// pc_ctrl  : instruction fetch PC controller (IDLE/FETCH/HOLD/HALT).
//            Define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets.
// Revision : 1.0
// ============================================================================
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        misaligned_fault
);

  state_e      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fault_q, fault_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        halt_pend_q, halt_pend_d;

  logic [31:0] live_target;
  logic        live_misaligned;
  logic        stop;
  logic        trap;
  nsel_e       sel;
  logic [31:0] sel_target;

`ifdef PC_MISALIGN_TRAP_EN
  assign live_target     = redirect_target;
  assign live_misaligned = |redirect_target[1:0];
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb  = ^redirect_target[1:0];
  assign live_target     = {redirect_target[31:2], 2'b00};
  assign live_misaligned = 1'b0;
`endif

  // A halt (live or remembered) outranks any redirect, including a faulting one.
  assign stop = halt | halt_pend_q;
  assign trap = redirect_valid & live_misaligned & ~stop;

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    halt_pend_d   = halt_pend_q;
    fetch_valid_d = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    fault_d       = 1'b0;
    sel           = SEL_HOLD;
    sel_target    = live_target;

    unique case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (trap) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          if (redirect_valid) sel = SEL_TARGET;
        end
      end

      ST_FETCH: begin
        if (imem_ack) begin
          pend_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (stop || trap) begin
            fault_d = trap;
            state_d = ST_HALT;
          end else if (redirect_valid || pend_valid_q) begin
            // Response belongs to the wrong path: drop it, live redirect wins.
            sel        = SEL_TARGET;
            sel_target = redirect_valid ? live_target : pend_target_q;
            state_d    = stall ? ST_HOLD : ST_FETCH;
          end else begin
            fetch_valid_d = 1'b1;
            fetch_pc_d    = imem_addr_q;
            sel           = SEL_SEQ;
            state_d       = stall ? ST_HOLD : ST_FETCH;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end else if (trap) begin
          fault_d     = 1'b1;
          halt_pend_d = 1'b1;
        end else if (redirect_valid && !halt_pend_q) begin
          pend_valid_d  = 1'b1;
          pend_target_d = live_target;
        end
      end

      ST_HOLD: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (trap) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          if (redirect_valid) sel = SEL_TARGET;
          state_d = stall ? ST_HOLD : ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: state_d = ST_IDLE;
    endcase

    imem_req_d = (state_d == ST_FETCH);
  end

  pc_next_sel u_next_sel (
    .cur_addr  (imem_addr_q),
    .target    (sel_target),
    .sel       (sel),
    .next_addr (imem_addr_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= 32'h0;
      fault_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      halt_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fault_q       <= fault_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      halt_pend_q   <= halt_pend_d;
    end
  end

  assign imem_req         = imem_req_q;
  assign imem_addr        = imem_addr_q;
  assign fetch_valid      = fetch_valid_q;
  assign fetch_pc         = fetch_pc_q;
  assign misaligned_fault = fault_q;

endmodule : pc_ctrl
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pc_ctrl : directed bench for pc_ctrl with a fetch_pc scoreboard queue
// Revision   : 1.0
// ============================================================================
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        misaligned_fault;

  logic        ack2;
  logic        req2;
  logic [31:0] addr2;
  logic        fv2;
  logic [31:0] pc2;
  logic        fault2;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_ctrl u_dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .halt             (halt),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .misaligned_fault (misaligned_fault)
  );

  pc_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_wrap (
    .clk              (clk),
    .rst              (rst),
    .stall            (1'b0),
    .redirect_valid   (1'b0),
    .redirect_target  (32'h0),
    .halt             (1'b0),
    .imem_req         (req2),
    .imem_addr        (addr2),
    .imem_ack         (ack2),
    .fetch_valid      (fv2),
    .fetch_pc         (pc2),
    .misaligned_fault (fault2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Every accepted ack yields exactly one fetch_valid on the following cycle.
  task automatic step();
    logic [31:0] exp_pc;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      exp_pc = exp_q.pop_front();
      chk("sb_fetch_valid", {31'h0, fetch_valid}, 32'd1);
      chk("sb_fetch_pc", fetch_pc, exp_pc);
    end else begin
      chk("sb_no_fetch_valid", {31'h0, fetch_valid}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    halt = 1'b0; imem_ack = 1'b0; ack2 = 1'b0;
    step(); step();
    chk("rst_req",   {31'h0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_pc",    fetch_pc, 32'h0);
    chk("rst_fault", {31'h0, misaligned_fault}, 32'd0);
    chk("rst_addr2", addr2, 32'hFFFF_FFFC);

    // One IDLE cycle, then first request at RESET_VECTOR
    rst = 1'b0;
    step();
    chk("first_req",  {31'h0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Back-to-back acks: 0x0, 0x4, 0x8
    imem_ack = 1'b1;
    exp_q.push_back(32'h0); step(); chk("seq_addr4", imem_addr, 32'h4);
    exp_q.push_back(32'h4); step(); chk("seq_addr8", imem_addr, 32'h8);
    exp_q.push_back(32'h8); step(); chk("seq_addrC", imem_addr, 32'hC);

    // Delayed ack at 0xC with a redirect in the second wait cycle
    imem_ack = 1'b0; stall = 1'b1;
    step(); chk("wait1_addr", imem_addr, 32'hC); chk("wait1_req", {31'h0, imem_req}, 32'd1);
    stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
    step(); chk("wait2_addr", imem_addr, 32'hC);
    redirect_valid = 1'b0;
    step(); chk("wait3_addr", imem_addr, 32'hC);
    imem_ack = 1'b1;
    step(); chk("pend_redir_addr", imem_addr, 32'h100); chk("pend_redir_req", {31'h0, imem_req}, 32'd1);

    // Redirect coinciding with ack
    redirect_valid = 1'b1; redirect_target = 32'h2000;
    step(); chk("ack_redir_addr", imem_addr, 32'h2000);

    // Misaligned redirect target coinciding with ack
    redirect_target = 32'h102;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_fault", {31'h0, misaligned_fault}, 32'd1);
    chk("mis_req",   {31'h0, imem_req}, 32'd0);
`else
    chk("mis_fault", {31'h0, misaligned_fault}, 32'd0);
    chk("mis_addr",  imem_addr, 32'h100);
`endif
    imem_ack = 1'b0; redirect_valid = 1'b0;
    step(); chk("mis_fault_pulse", {31'h0, misaligned_fault}, 32'd0);

    // Asynchronous reset while a request is outstanding
    rst = 1'b1;
    #1;
    chk("async_req",  {31'h0, imem_req}, 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    step();
    imem_ack = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rel_req",  {31'h0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);

    // Stall raised at the ack of 0x4 for four cycles
    exp_q.push_back(32'h0); step(); chk("st_addr4", imem_addr, 32'h4);
    stall = 1'b1;
    exp_q.push_back(32'h4); step();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_req",  {31'h0, imem_req}, 32'd0);
      chk("hold_addr", imem_addr, 32'h8);
      stall = (i < 3);
      step();
    end
    chk("resume_req",  {31'h0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h8);

    // Halt with an outstanding request: request completes, ack discarded
    halt = 1'b1;
    step(); chk("halt_wait_req", {31'h0, imem_req}, 32'd1);
    halt = 1'b0;
    step(); chk("halt_wait2_req", {31'h0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    step(); chk("halt_req", {31'h0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'h300;
    step(); chk("halt_ign_req", {31'h0, imem_req}, 32'd0); chk("halt_ign_addr", imem_addr, 32'h8);
    step(); chk("halt_ign2_req", {31'h0, imem_req}, 32'd0);
    imem_ack = 1'b0; redirect_valid = 1'b0;

    // Wrap of the sequential address past 0xFFFF_FFFC
    ack2 = 1'b1;
    step();
    chk("wrap_fv1", {31'h0, fv2}, 32'd1);
    chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
    chk("wrap_addr", addr2, 32'h0);
    step();
    chk("wrap_fv2", {31'h0, fv2}, 32'd1);
    chk("wrap_pc2", pc2, 32'h0);
    chk("wrap_fault", {31'h0, fault2}, 32'd0);
    ack2 = 1'b0;
    step();

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pc_ctrl
`default_nettype wire

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
- REQ-001 SHALL have parameter: RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
- REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
- REQ-004 SHALL have port: stall  in  1  pipeline hold request from downstream.
- REQ-005 SHALL have port: redirect_valid  in  1  taken branch/jump from execute.
- REQ-006 SHALL have port: redirect_target  in  32  redirect address (PC + immediate).
- REQ-007 SHALL have port: halt  in  1  enter HALT; exit only via reset.
- REQ-008 SHALL have port: imem_req  out  1  fetch request to instruction memory.
- REQ-009 SHALL have port: imem_addr  out  32  fetch address, stable while imem_req=1 and no ack.
- REQ-010 SHALL have port: imem_ack  in  1  fetch complete; sampled only while imem_req=1.
- REQ-011 SHALL have port: fetch_valid  out  1  one-cycle pulse marking a valid fetched instruction.
- REQ-012 SHALL have port: fetch_pc  out  32  address of the instruction flagged by fetch_valid.
- REQ-013 SHALL have port: misaligned_fault  out  1  one-cycle pulse on misaligned redirect.

Function
- REQ-014 SHALL implement FSM states IDLE, FETCH, HOLD, HALT; priority halt > redirect > stall > sequential.
- REQ-015 IDLE SHALL last exactly one cycle after reset release, then enter FETCH with imem_req=1, imem_addr=RESET_VECTOR.
- REQ-016 FETCH SHALL hold imem_req=1 and imem_addr constant until imem_ack; stall without ack has no effect.
- REQ-017 On ack (cycle N) with no discard, fetch_valid=1 and fetch_pc=old imem_addr SHALL appear in cycle N+1.
- REQ-018 On ack, next imem_addr SHALL be imem_addr+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- REQ-019 On ack with stall=1, state SHALL become HOLD (imem_req=0) at N+1; otherwise FETCH with back-to-back request at N+1.
- REQ-020 HOLD SHALL return to FETCH the cycle after stall is sampled 0.
- REQ-021 redirect in FETCH without ack SHALL latch a pending target (latest wins); the next ack SHALL be discarded (no fetch_valid) and the next imem_addr SHALL be the pending target.
- REQ-022 redirect in the same cycle as ack SHALL discard that response and set the next imem_addr to redirect_target.
- REQ-023 redirect in IDLE or HOLD SHALL load imem_addr with redirect_target directly; HOLD is kept if stall=1.
- REQ-024 halt SHALL move to HALT next cycle from any state; an outstanding request SHALL complete first, with its ack discarded, and imem_req=0 in HALT.
- REQ-025 redirect, stall and imem_ack SHALL be ignored in HALT.

Reset
- REQ-026 rst=1 SHALL asynchronously force state=IDLE, imem_req=0, imem_addr=RESET_VECTOR, fetch_valid=0, fetch_pc=0, misaligned_fault=0, and clear the pending redirect.
- REQ-027 Reset mid-fetch SHALL abandon the request; any ack after reset release and before the first request SHALL be ignored.

Configuration
- REQ-028 Macro PC_MISALIGN_TRAP_EN defined: redirect_target[1:0]!=0 SHALL pulse misaligned_fault for one cycle and enter HALT; the target is not used.
- REQ-029 Macro PC_MISALIGN_TRAP_EN undefined: redirect_target[1:0] SHALL be forced to 0, and misaligned_fault SHALL be tied 0.

Structure
- REQ-030 Package pc_ctrl_pkg SHALL hold the state encoding, PC_STEP=4 and the default RESET_VECTOR.
- REQ-031 Next-address selection SHALL be a combinational sub-module pc_next_sel (inputs: current addr, pending/live target, select; output: next addr).

Verification
- REQ-032 Reset release, ack every cycle -> fetch_valid pulses with fetch_pc 0x0, 0x4, 0x8 on consecutive cycles.
- REQ-033 Ack delayed 3 cycles at 0x8, redirect_valid=1 (target 0x100) in the 2nd wait cycle -> no fetch_valid for 0x8; next imem_addr=0x100.
- REQ-034 stall=1 at ack of 0x4 for 4 cycles -> imem_req=0 for 4 cycles, then request 0x8.
- REQ-035 RESET_VECTOR=32'hFFFF_FFFC -> fetch_pc 0xFFFFFFFC, then 0x00000000.
- REQ-036 redirect target 0x102: with macro, misaligned_fault pulse and HALT (imem_req=0); without macro, next imem_addr=0x100.
- REQ-037 rst asserted while imem_req=1 awaiting ack -> imem_req=0 immediately and no fetch_valid; first request after release is RESET_VECTOR.
